// File: rtl/div_seq_if.sv
// Handshake and operand/result bundle for the sequential divider.
interface div_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, is_signed, src_a, src_b,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, is_signed, src_a, src_b,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/div_seq.sv
// Restoring sequential divider: one quotient bit per cycle on magnitudes, then sign fix.
// Quotient to lo, remainder to hi; divide-by-zero resolves in the accept cycle.
module div_seq #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  div_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_mag, b_mag, r, q, hi, lo;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, done, div_zero;

  logic             a_neg, b_neg, b_zero, accept;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   r_sh, r_sub;
  logic             r_ge;

  assign a_neg  = bus.is_signed & bus.src_a[WIDTH-1];
  assign b_neg  = bus.is_signed & bus.src_b[WIDTH-1];
  assign a_abs  = a_neg ? -bus.src_a : bus.src_a;
  assign b_abs  = b_neg ? -bus.src_b : bus.src_b;
  assign b_zero = (bus.src_b == '0);
  assign accept = (state == IDLE) & bus.start;

  // Extra top bit keeps the carry out of the shifted partial remainder.
  assign r_sh  = {r, a_mag[cnt]};
  assign r_sub = r_sh - {1'b0, b_mag};
  assign r_ge  = (r_sh >= {1'b0, b_mag});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !b_zero) state_nxt = RUN;
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_mag    <= '0;
      b_mag    <= '0;
      r        <= '0;
      q        <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (b_zero) begin
            lo       <= '1;
            hi       <= bus.src_a;
            div_zero <= 1'b1;
            done     <= 1'b1;
          end else begin
            a_mag <= a_abs;
            b_mag <= b_abs;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            r     <= '0;
            q     <= '0;
            cnt   <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          r <= r_ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
          q <= {q[WIDTH-2:0], r_ge};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          // MIN / -1 needs nothing special: -2^(W-1) wraps back to MIN.
          lo       <= neg_q ? -q : q;
          hi       <= neg_r ? -r : r;
          div_zero <= 1'b0;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done;
  assign bus.div_zero = div_zero;
  assign bus.hi       = hi;
  assign bus.lo       = lo;
endmodule
